// File: rtl/hps_reset_pulse_sequencer.sv
// Edge-to-pulse sequencer for FPGA-to-HPS reset requests: synchronises request levels,
// detects configured edges and emits stretched, optionally priority-serialised pulses.
module hps_reset_pulse_sequencer #(
  parameter int                            NUM_CH                = 3,
  parameter int                            PULSE_EXT_W           = 6,
  parameter logic [NUM_CH*PULSE_EXT_W-1:0] PULSE_EXT             = {6'd32, 6'd2, 6'd6},
  parameter logic [NUM_CH*2-1:0]           EDGE_TYPE             = {2'b01, 2'b01, 2'b01},
  parameter logic [NUM_CH-1:0]             IGNORE_RST_WHILE_BUSY = {NUM_CH{1'b1}},
  parameter int                            SYNC_STAGES           = 2,
  parameter bit                            EXCLUSIVE             = 1'b1,
  parameter int                            GAP_CYCLES            = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] signal_in,
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] pulse_out_n,
  output logic [NUM_CH-1:0] pending,
  output logic              busy,
  output logic [NUM_CH-1:0] dropped,
  input  logic              clear_dropped
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int GAP_W  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_GAP    = 2'b10
  } state_t;

  logic [SYNC_N-1:0][NUM_CH-1:0]      sync_q, sync_d;
  logic [NUM_CH-1:0]                  prev_q, prev_d;
  logic [NUM_CH-1:0]                  pending_q, pending_d;
  logic [NUM_CH-1:0]                  pulse_q, pulse_d;
  logic [NUM_CH-1:0]                  pulse_n_q, pulse_n_d;
  logic [NUM_CH-1:0]                  dropped_q, dropped_d;
  logic                               busy_q, busy_d;
  logic [NUM_CH-1:0][PULSE_EXT_W-1:0] cnt_q, cnt_d, cnt_run_s;
  logic [GAP_W-1:0]                   gap_q, gap_d;
  state_t                             state_q, state_d, state_rst_s;
  logic [IDX_W-1:0]                   act_idx_q, act_idx_d, pri_idx_s;
  logic [NUM_CH-1:0]                  edge_s, end_s, pulse_run_s, pulse_keep_s, start_s;
  logic                               act_end_s;

  function automatic logic edge_hit(input logic [1:0] et, input logic cur, input logic prv);
    logic hit;
    case (et)
      2'b01:   hit = cur & ~prv;
      2'b10:   hit = ~cur & prv;
      2'b11:   hit = cur ^ prv;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Counter load value: a pulse of length L needs L-1 further cycles; 0 and 1 both give one cycle.
  function automatic logic [PULSE_EXT_W-1:0] load_val(input int ch);
    logic [PULSE_EXT_W-1:0] len;
    len = PULSE_EXT[ch*PULSE_EXT_W +: PULSE_EXT_W];
    return (len == {PULSE_EXT_W{1'b0}}) ? {PULSE_EXT_W{1'b0}} : len - PULSE_EXT_W'(1);
  endfunction

  always_comb begin
    edge_s      = {NUM_CH{1'b0}};
    end_s       = {NUM_CH{1'b0}};
    pulse_run_s = pulse_q;
    cnt_run_s   = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      edge_s[i] = edge_hit(EDGE_TYPE[2*i +: 2], sync_q[SYNC_N-1][i], prev_q[i]);
      end_s[i]  = pulse_q[i] && (cnt_q[i] == {PULSE_EXT_W{1'b0}});
      if (end_s[i]) begin
        pulse_run_s[i] = 1'b0;
      end else if (pulse_q[i]) begin
        cnt_run_s[i] = cnt_q[i] - PULSE_EXT_W'(1);
      end else begin
        cnt_run_s[i] = cnt_q[i];
      end
    end
    pulse_keep_s = pulse_run_s & IGNORE_RST_WHILE_BUSY;
  end

  always_comb begin
    pri_idx_s = {IDX_W{1'b0}};
    act_end_s = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      pri_idx_s = pending_q[i] ? IDX_W'(i) : pri_idx_s;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      act_end_s = act_end_s | (end_s[i] && (act_idx_q == IDX_W'(i)));
    end
  end

  // Arbiter: starts are only granted from a registered IDLE, so entering IDLE never starts a pulse.
  always_comb begin
    state_d   = state_q;
    act_idx_d = act_idx_q;
    gap_d     = gap_q;
    start_s   = {NUM_CH{1'b0}};
    if (!EXCLUSIVE) begin
      start_s = pending_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pending_q) begin
            state_d   = ST_ACTIVE;
            act_idx_d = pri_idx_s;
            for (int i = 0; i < NUM_CH; i++) begin
              start_s[i] = (pri_idx_s == IDX_W'(i));
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (act_end_s) begin
            if (GAP_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end
          end else begin
            state_d = ST_ACTIVE;
          end
        end
        ST_GAP: begin
          if (gap_q == {GAP_W{1'b0}}) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sync_d    = {sync_q[SYNC_N-2:0], signal_in};
    prev_d    = sync_q[SYNC_N-1];
    pulse_d   = pulse_run_s;
    cnt_d     = cnt_run_s;
    pending_d = pending_q;
    dropped_d = clear_dropped ? {NUM_CH{1'b0}} : dropped_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (edge_s[i] && (pending_q[i] || pulse_q[i])) begin
        dropped_d[i] = 1'b1;
      end else if (edge_s[i]) begin
        pending_d[i] = 1'b1;
      end else begin
        pending_d[i] = pending_q[i];
      end
      if (start_s[i]) begin
        pulse_d[i]   = 1'b1;
        cnt_d[i]     = load_val(i);
        pending_d[i] = 1'b0;
      end else begin
        cnt_d[i] = cnt_run_s[i];
      end
    end
    pulse_n_d   = ~pulse_d;
    busy_d      = (|pulse_d) || (state_d == ST_GAP);
    state_rst_s = (EXCLUSIVE && (|pulse_keep_s)) ? ST_ACTIVE : ST_IDLE;
  end

  // Masked channels with a live pulse keep counting through reset; everything else clears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= {(SYNC_N*NUM_CH){1'b0}};
      prev_q    <= {NUM_CH{1'b0}};
      pending_q <= {NUM_CH{1'b0}};
      dropped_q <= {NUM_CH{1'b0}};
      gap_q     <= {GAP_W{1'b0}};
      pulse_q   <= pulse_keep_s;
      pulse_n_q <= ~pulse_keep_s;
      busy_q    <= |pulse_keep_s;
      state_q   <= state_rst_s;
      act_idx_q <= act_idx_q;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= IGNORE_RST_WHILE_BUSY[i] ? cnt_run_s[i] : {PULSE_EXT_W{1'b0}};
      end
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      gap_q     <= gap_d;
      pulse_q   <= pulse_d;
      pulse_n_q <= pulse_n_d;
      busy_q    <= busy_d;
      state_q   <= state_d;
      act_idx_q <= act_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pulse_out   = pulse_q;
  assign pulse_out_n = pulse_n_q;
  assign pending     = pending_q;
  assign busy        = busy_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_hps_reset_pulse_sequencer.sv
// Scoreboard bench: expected per-cycle output values are queued when stimulus is driven
// and compared on the falling edge of the cycle they refer to.
module tb_hps_reset_pulse_sequencer;

  localparam int SIG_PULSE = 0, SIG_PULSEN = 1, SIG_PEND = 2, SIG_DROP = 3, SIG_BUSY = 4;
  localparam int IA = 0, IB = 1, IC = 2, ID = 3;

  logic            clk = 1'b0;
  logic [3:0]      rst_n_v;
  logic [3:0]      clr_v;
  logic [3:0][2:0] sig_v, po_v, pon_v, pend_v, drp_v;
  logic [3:0]      bsy_v;
  int              cyc = 0;
  int              n_checks = 0;
  int              n_errors = 0;
  int              t0;

  typedef struct {
    int         cyc;
    int         inst;
    int         sig;
    logic [2:0] mask;
    logic [2:0] exp;
    string      tag;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: defaults, B: independent channels, C: ch0 both edges + ch2 unmasked, D: ch0 disabled
  hps_reset_pulse_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n_v[IA]), .signal_in(sig_v[IA]), .pulse_out(po_v[IA]),
    .pulse_out_n(pon_v[IA]), .pending(pend_v[IA]), .busy(bsy_v[IA]), .dropped(drp_v[IA]),
    .clear_dropped(clr_v[IA]));

  hps_reset_pulse_sequencer #(.EXCLUSIVE(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n_v[IB]), .signal_in(sig_v[IB]), .pulse_out(po_v[IB]),
    .pulse_out_n(pon_v[IB]), .pending(pend_v[IB]), .busy(bsy_v[IB]), .dropped(drp_v[IB]),
    .clear_dropped(clr_v[IB]));

  hps_reset_pulse_sequencer #(.EDGE_TYPE({2'b01, 2'b01, 2'b11}),
                              .IGNORE_RST_WHILE_BUSY(3'b011)) u_dut_c (
    .clk(clk), .rst_n(rst_n_v[IC]), .signal_in(sig_v[IC]), .pulse_out(po_v[IC]),
    .pulse_out_n(pon_v[IC]), .pending(pend_v[IC]), .busy(bsy_v[IC]), .dropped(drp_v[IC]),
    .clear_dropped(clr_v[IC]));

  hps_reset_pulse_sequencer #(.EDGE_TYPE({2'b01, 2'b01, 2'b00})) u_dut_d (
    .clk(clk), .rst_n(rst_n_v[ID]), .signal_in(sig_v[ID]), .pulse_out(po_v[ID]),
    .pulse_out_n(pon_v[ID]), .pending(pend_v[ID]), .busy(bsy_v[ID]), .dropped(drp_v[ID]),
    .clear_dropped(clr_v[ID]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [2:0] obs(input int inst, input int sig);
    case (sig)
      SIG_PULSE:  return po_v[inst];
      SIG_PULSEN: return pon_v[inst];
      SIG_PEND:   return pend_v[inst];
      SIG_DROP:   return drp_v[inst];
      SIG_BUSY:   return {2'b00, bsy_v[inst]};
      default:    return 3'b000;
    endcase
  endfunction

  task automatic push_win(input int base, input int k0, input int k1, input int inst,
                          input int sig, input logic [2:0] mask, input logic [2:0] val,
                          input string name);
    for (int k = k0; k <= k1; k++) begin
      exp_t e;
      e.cyc  = base + k;
      e.inst = inst;
      e.sig  = sig;
      e.mask = mask;
      e.exp  = val;
      e.tag  = $sformatf("%s@t0+%0d", name, k);
      sb_q.push_back(e);
    end
  endtask

  task automatic at_edge(input int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        check_eq(sb_q[i].tag, {29'd0, obs(sb_q[i].inst, sb_q[i].sig) & sb_q[i].mask},
                 {29'd0, sb_q[i].exp});
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_v = 4'h0;
    clr_v   = 4'h0;
    sig_v   = 12'h000;
    repeat (3) @(negedge clk);
    rst_n_v = 4'hF;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_eq("rst.pulse", {29'd0, po_v[k]}, 32'd0);
      check_eq("rst.pulse_n", {29'd0, pon_v[k]}, 32'd7);
      check_eq("rst.pending", {29'd0, pend_v[k]}, 32'd0);
      check_eq("rst.dropped", {29'd0, drp_v[k]}, 32'd0);
      check_eq("rst.busy", {31'd0, bsy_v[k]}, 32'd0);
    end

    // Single rising edge on ch0
    t0 = cyc + 3;
    at_edge(t0);
    sig_v[IA][0] = 1'b1;
    push_win(t0, 1, 1, IA, SIG_PEND, 3'b001, 3'b000, "A.pend0");
    push_win(t0, 2, 2, IA, SIG_PEND, 3'b001, 3'b001, "A.pend0");
    push_win(t0, 3, 3, IA, SIG_PEND, 3'b001, 3'b000, "A.pend0");
    push_win(t0, 2, 2, IA, SIG_PULSE, 3'b001, 3'b000, "A.pulse0");
    push_win(t0, 3, 8, IA, SIG_PULSE, 3'b001, 3'b001, "A.pulse0");
    push_win(t0, 9, 9, IA, SIG_PULSE, 3'b001, 3'b000, "A.pulse0");
    push_win(t0, 3, 8, IA, SIG_PULSEN, 3'b001, 3'b000, "A.pulse_n0");
    push_win(t0, 9, 9, IA, SIG_PULSEN, 3'b001, 3'b001, "A.pulse_n0");
    push_win(t0, 3, 12, IA, SIG_BUSY, 3'b001, 3'b001, "A.busy");
    push_win(t0, 13, 13, IA, SIG_BUSY, 3'b001, 3'b000, "A.busy");
    at_edge(t0 + 20);
    sig_v[IA][0] = 1'b0;
    at_edge(t0 + 30);

    // ch0 and ch1 together: priority, gap, then ch1
    t0 = cyc + 3;
    at_edge(t0);
    sig_v[IA][1:0] = 2'b11;
    push_win(t0, 3, 8, IA, SIG_PULSE, 3'b001, 3'b001, "A.pulse0");
    push_win(t0, 9, 9, IA, SIG_PULSE, 3'b001, 3'b000, "A.pulse0");
    push_win(t0, 1, 1, IA, SIG_PEND, 3'b010, 3'b000, "A.pend1");
    push_win(t0, 2, 13, IA, SIG_PEND, 3'b010, 3'b010, "A.pend1");
    push_win(t0, 14, 14, IA, SIG_PEND, 3'b010, 3'b000, "A.pend1");
    push_win(t0, 8, 13, IA, SIG_PULSE, 3'b010, 3'b000, "A.pulse1");
    push_win(t0, 14, 15, IA, SIG_PULSE, 3'b010, 3'b010, "A.pulse1");
    push_win(t0, 16, 16, IA, SIG_PULSE, 3'b010, 3'b000, "A.pulse1");
    push_win(t0, 13, 13, IA, SIG_BUSY, 3'b001, 3'b000, "A.busy");
    push_win(t0, 14, 19, IA, SIG_BUSY, 3'b001, 3'b001, "A.busy");
    push_win(t0, 20, 20, IA, SIG_BUSY, 3'b001, 3'b000, "A.busy");
    at_edge(t0 + 25);
    sig_v[IA][1:0] = 2'b00;
    at_edge(t0 + 30);

    // ch2 retrigger during its 32-cycle pulse, then clear_dropped
    t0 = cyc + 3;
    at_edge(t0);
    sig_v[IA][2] = 1'b1;
    push_win(t0, 3, 34, IA, SIG_PULSE, 3'b100, 3'b100, "A.pulse2");
    push_win(t0, 35, 35, IA, SIG_PULSE, 3'b100, 3'b000, "A.pulse2");
    push_win(t0, 15, 15, IA, SIG_DROP, 3'b100, 3'b000, "A.drop2");
    push_win(t0, 16, 39, IA, SIG_DROP, 3'b100, 3'b100, "A.drop2");
    push_win(t0, 40, 41, IA, SIG_DROP, 3'b100, 3'b000, "A.drop2");
    push_win(t0, 16, 17, IA, SIG_PEND, 3'b100, 3'b000, "A.pend2");
    push_win(t0, 38, 38, IA, SIG_BUSY, 3'b001, 3'b001, "A.busy");
    push_win(t0, 39, 39, IA, SIG_BUSY, 3'b001, 3'b000, "A.busy");
    at_edge(t0 + 10);
    sig_v[IA][2] = 1'b0;
    at_edge(t0 + 14);
    sig_v[IA][2] = 1'b1;
    at_edge(t0 + 40);
    clr_v[IA] = 1'b1;
    at_edge(t0 + 41);
    clr_v[IA] = 1'b0;
    at_edge(t0 + 45);
    sig_v[IA][2] = 1'b0;
    at_edge(t0 + 50);

    // One-cycle reset at pulse cycle 3 of ch2: masked (A) survives, unmasked (C) is cut
    t0 = cyc + 3;
    at_edge(t0);
    sig_v[IA][2] = 1'b1;
    sig_v[IC][2] = 1'b1;
    push_win(t0, 3, 34, IA, SIG_PULSE, 3'b100, 3'b100, "A.rst_pulse2");
    push_win(t0, 35, 35, IA, SIG_PULSE, 3'b100, 3'b000, "A.rst_pulse2");
    push_win(t0, 5, 5, IA, SIG_BUSY, 3'b001, 3'b001, "A.rst_busy");
    push_win(t0, 7, 7, IA, SIG_DROP, 3'b100, 3'b000, "A.rst_drop2");
    push_win(t0, 8, 8, IA, SIG_DROP, 3'b100, 3'b100, "A.rst_drop2");
    push_win(t0, 3, 4, IC, SIG_PULSE, 3'b100, 3'b100, "C.rst_pulse2");
    push_win(t0, 5, 8, IC, SIG_PULSE, 3'b100, 3'b000, "C.rst_pulse2");
    push_win(t0, 5, 5, IC, SIG_BUSY, 3'b001, 3'b000, "C.rst_busy");
    push_win(t0, 7, 7, IC, SIG_PEND, 3'b100, 3'b000, "C.rst_pend2");
    push_win(t0, 8, 8, IC, SIG_PEND, 3'b100, 3'b100, "C.rst_pend2");
    push_win(t0, 9, 9, IC, SIG_PEND, 3'b100, 3'b000, "C.rst_pend2");
    push_win(t0, 9, 40, IC, SIG_PULSE, 3'b100, 3'b100, "C.re_pulse2");
    push_win(t0, 41, 41, IC, SIG_PULSE, 3'b100, 3'b000, "C.re_pulse2");
    push_win(t0, 8, 8, IC, SIG_DROP, 3'b100, 3'b000, "C.rst_drop2");
    at_edge(t0 + 5);
    rst_n_v[IA] = 1'b0;
    rst_n_v[IC] = 1'b0;
    at_edge(t0 + 6);
    rst_n_v[IA] = 1'b1;
    rst_n_v[IC] = 1'b1;
    at_edge(t0 + 45);
    sig_v[IA][2] = 1'b0;
    sig_v[IC][2] = 1'b0;
    at_edge(t0 + 50);

    // Both-edge channel (C ch0) and disabled channel (D ch0): high then low 10 cycles later
    t0 = cyc + 3;
    at_edge(t0);
    sig_v[IC][0] = 1'b1;
    sig_v[ID][0] = 1'b1;
    push_win(t0, 2, 2, IC, SIG_PULSE, 3'b001, 3'b000, "C.both_pulse0");
    push_win(t0, 3, 8, IC, SIG_PULSE, 3'b001, 3'b001, "C.both_pulse0");
    push_win(t0, 9, 13, IC, SIG_PULSE, 3'b001, 3'b000, "C.both_pulse0");
    push_win(t0, 14, 19, IC, SIG_PULSE, 3'b001, 3'b001, "C.both_pulse0");
    push_win(t0, 20, 20, IC, SIG_PULSE, 3'b001, 3'b000, "C.both_pulse0");
    push_win(t0, 12, 13, IC, SIG_PEND, 3'b001, 3'b001, "C.both_pend0");
    push_win(t0, 14, 14, IC, SIG_PEND, 3'b001, 3'b000, "C.both_pend0");
    push_win(t0, 13, 13, IC, SIG_DROP, 3'b001, 3'b000, "C.both_drop0");
    push_win(t0, 2, 20, ID, SIG_PULSE, 3'b001, 3'b000, "D.off_pulse0");
    push_win(t0, 2, 20, ID, SIG_PEND, 3'b001, 3'b000, "D.off_pend0");
    push_win(t0, 20, 20, ID, SIG_DROP, 3'b001, 3'b000, "D.off_drop0");
    push_win(t0, 4, 4, ID, SIG_BUSY, 3'b001, 3'b000, "D.off_busy");
    at_edge(t0 + 10);
    sig_v[IC][0] = 1'b0;
    sig_v[ID][0] = 1'b0;
    at_edge(t0 + 30);

    // Independent channels: all three rise together
    t0 = cyc + 3;
    at_edge(t0);
    sig_v[IB] = 3'b111;
    push_win(t0, 2, 2, IB, SIG_PEND, 3'b111, 3'b111, "B.pend");
    push_win(t0, 3, 3, IB, SIG_PEND, 3'b111, 3'b000, "B.pend");
    push_win(t0, 2, 2, IB, SIG_PULSE, 3'b111, 3'b000, "B.pulse");
    push_win(t0, 3, 4, IB, SIG_PULSE, 3'b111, 3'b111, "B.pulse");
    push_win(t0, 5, 8, IB, SIG_PULSE, 3'b111, 3'b101, "B.pulse");
    push_win(t0, 9, 34, IB, SIG_PULSE, 3'b111, 3'b100, "B.pulse");
    push_win(t0, 35, 35, IB, SIG_PULSE, 3'b111, 3'b000, "B.pulse");
    push_win(t0, 3, 34, IB, SIG_BUSY, 3'b001, 3'b001, "B.busy");
    push_win(t0, 35, 35, IB, SIG_BUSY, 3'b001, 3'b000, "B.busy");
    at_edge(t0 + 40);
    sig_v[IB] = 3'b000;
    at_edge(t0 + 45);

    for (int k = 0; k < 200 && sb_q.size() > 0; k++) @(negedge clk);
    check_eq("sb_drain", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hps_reset_pulse_sequencer.md
Name: hps_reset_pulse_sequencer

Overview:
Multi-channel edge-to-pulse generator for FPGA-to-HPS reset requests (cold/warm/debug and similar). Each channel synchronises a request level, detects a configured edge, and emits a stretched pulse of per-channel length. It optionally serialises channels by priority, with an inter-pulse gap, so that only one reset request is active at a time. It sits between the ISSP/soft request sources and the active-low HPS reset-request inputs.

Parameters:
NUM_CH, 3, number of channels; index 0 has the highest priority.
PULSE_EXT_W, 6, width of each pulse-length field and of the per-channel counter.
PULSE_EXT, {6'd32,6'd2,6'd6}, packed NUM_CH*PULSE_EXT_W; field i is the pulse length of channel i in cycles; a value of 0 is treated as 1.
EDGE_TYPE, {2'b01,2'b01,2'b01}, packed NUM_CH*2; per channel: 01 rising, 10 falling, 11 both, 00 channel disabled.
IGNORE_RST_WHILE_BUSY, {NUM_CH{1'b1}}, per-channel mask; an active pulse on a set channel survives rst_n.
SYNC_STAGES, 2, input synchroniser depth; minimum 2.
EXCLUSIVE, 1, 1 = at most one pulse active at a time, arbitrated by priority; 0 = channels fully independent.
GAP_CYCLES, 4, idle cycles after any pulse ends before the next pulse may start (EXCLUSIVE=1 only); 0 means no gap.

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
signal_in  in  NUM_CH  request levels; may be asynchronous to clk.
pulse_out  out  NUM_CH  active-high stretched pulses.
pulse_out_n  out  NUM_CH  ~pulse_out; drives HPS *_req_reset_n directly.
pending  out  NUM_CH  edge detected, pulse not yet started.
busy  out  1  any pulse active, or gap counter running.
dropped  out  NUM_CH  sticky: an edge arrived while the channel was pending or active.
clear_dropped  in  1  synchronous clear of dropped (all bits).

Behaviour:
- Reset (rst_n=0 at a clk edge) clears the sync chain, prev, pending, gap counter and dropped.
- Also at reset: pulse_out is cleared for every channel with IGNORE_RST_WHILE_BUSY=0.
- Channels with the mask bit set and a pulse active keep counting and hold pulse_out=1 to completion; an idle masked channel resets to 0.
- Reset values: pulse_out=0, pulse_out_n=1, pending=0, busy=0 (except surviving pulses), dropped=0.
- Sync chain and prev reset to 0, so a request held high through reset yields one rising edge after release.
- Sync: SYNC_STAGES flops per channel; prev = registered last stage; edge = configured function of (last stage, prev).
- Latency: input sampled by sync[0] at edge t0 -> pending set at edge t0+SYNC_STAGES -> pulse_out high from edge t0+SYNC_STAGES+1 if the channel may start. With defaults, the pulse starts 3 cycles after sampling.
- Pulse: pulse_out stays high exactly PULSE_EXT[i] cycles (min 1); the counter loads at start and the pulse drops when the count expires. pending clears the same cycle the pulse starts.
- Retrigger: an edge detected while pending[i]=1 or pulse_out[i]=1 sets dropped[i]. Such an edge does not extend or requeue the pulse.
- clear_dropped and a new drop in the same cycle: dropped stays set.
- EXCLUSIVE=0: a pending channel starts on the next cycle unconditionally.
- EXCLUSIVE=1 states: IDLE -> ACTIVE(i) on any pending (lowest index wins) -> GAP when the pulse ends (skip to IDLE if GAP_CYCLES=0) -> IDLE after GAP_CYCLES cycles.
- Pending channels wait in IDLE; a higher-priority edge during ACTIVE/GAP is served first at the next IDLE.
- A start in the same cycle the FSM enters IDLE is not allowed; the first start occurs the cycle after.
- busy = |pulse_out | (state==GAP).
- Disabled channels (EDGE_TYPE 00) never set pending or dropped.

Test Plan:
- Defaults, rising edge on ch0 sampled at t0 -> pending[0] at t0+2; pulse_out[0]=1 for cycles t0+3..t0+8 (6 cycles); pulse_out_n[0] is the inverse; busy=1 through t0+12.
- ch0 and ch1 rise in the same cycle t0 -> ch0 pulses t0+3..t0+8; gap t0+9..t0+12; ch1 pulses t0+14..t0+15; pending[1]=1 from t0+2 to t0+13.
- EXCLUSIVE=0, all three channels rise at t0 -> pulse lengths 6/2/32 starting together at t0+3, independently.
- ch2 second rise while its 32-cycle pulse is active -> dropped[2]=1, pulse length unchanged. clear_dropped -> dropped[2]=0 next cycle.
- rst_n low for 1 cycle at pulse cycle 3 of ch2 -> pulse completes all 32 cycles. Repeat with mask bit 0 -> pulse_out[2]=0 the cycle after reset.
- EDGE_TYPE ch0=11, a high-then-low toggle 10 cycles apart -> two 6-cycle pulses; with EDGE_TYPE=00 -> no pulse, pending stays 0.
